xge_pkt_gen: RTL and testbench

- Synthesisable, parametrised packet traffic generator driving the xge_mac transmit packet interface (pkt_tx_*).
- Replaces buffer-driven bench stimulus. Usable both in simulation and in on-chip loopback/BIST builds.
- Generates a programmed number of packets with fixed or incrementing length and a deterministic byte pattern.
- Honours pkt_tx_full back-pressure and inserts a programmable inter-packet gap.

---
 rtl/xge_pkt_gen.sv | 220 ++++++++++++++++++++++
 tb/tb_xge_pkt_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xge_pkt_gen.sv
`default_nettype none
// ============================================================================
// Module   : xge_pkt_gen
// Function : Packet traffic generator driving the xge_mac pkt_tx interface.
// Revision : 1.0
// ============================================================================
module xge_pkt_gen #(
   parameter int DATA_W  = 64,
   parameter int MOD_W   = 3,
   parameter int LEN_W   = 14,
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 9600,
   parameter int CNT_W   = 32,
   parameter int GAP_W   = 8
) (
   input  logic              clk_156m25,
   input  logic              reset_156m25,
   input  logic              start,
   input  logic [CNT_W-1:0]  num_pkts,
   input  logic              stop,
   input  logic [LEN_W-1:0]  len_cfg,
   input  logic              len_incr,
   input  logic [GAP_W-1:0]  gap_cycles,
   input  logic              pkt_tx_full,
   output logic [DATA_W-1:0] pkt_tx_data,
   output logic              pkt_tx_val,
   output logic              pkt_tx_sop,
   output logic              pkt_tx_eop,
   output logic [MOD_W-1:0]  pkt_tx_mod,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  pkt_sent
);

   localparam int               c_bytes   = DATA_W / 8;
   localparam logic [LEN_W-1:0] c_min_len = LEN_W'(MIN_LEN);
   localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_send = 2'd1;
   localparam logic [1:0] c_gap  = 2'd2;
   localparam logic [1:0] c_done = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [LEN_W-1:0]  cur_len_q, cur_len_d;
   logic [LEN_W-1:0]  boff_q, boff_d;
   logic [CNT_W-1:0]  pkt_idx_q, pkt_idx_d;
   logic [CNT_W-1:0]  pkt_sent_q, pkt_sent_d;
   logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
   logic              stop_seen_q, stop_seen_d;
   logic [CNT_W-1:0]  num_pkts_q, num_pkts_d;
   logic              len_incr_q, len_incr_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              val_q, val_d;
   logic              sop_q, sop_d;
   logic              eop_q, eop_d;
   logic [MOD_W-1:0]  mod_q, mod_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              w_fire;
   logic              w_last;
   logic              w_finish;
   logic [CNT_W-1:0]  w_sent_inc;
   logic [DATA_W-1:0] w_word;

   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
      logic [LEN_W-1:0] r;
      r = l;
      if (l < c_min_len) r = c_min_len;
      else if (l > c_max_len) r = c_max_len;
      return r;
   endfunction

   assign w_fire     = (state_q == c_send) && !pkt_tx_full;
   assign w_last     = ({1'b0, boff_q} + (LEN_W+1)'(c_bytes)) >= {1'b0, cur_len_q};
   assign w_sent_inc = pkt_sent_q + CNT_W'(1);
   // A stop arriving on the eop edge itself still ends the run after this packet.
   assign w_finish   = ((num_pkts_q != '0) && (w_sent_inc == num_pkts_q)) || stop_seen_q || stop;

   // Byte lane j carries packet byte boff+j; lanes past the packet end read as zero.
   for (genvar j = 0; j < c_bytes; j++) begin : g_lane
      logic [LEN_W-1:0] w_k;
      assign w_k = boff_q + LEN_W'(j);
      assign w_word[DATA_W-1-8*j -: 8] = (w_k < cur_len_q) ? (pkt_idx_q[7:0] + w_k[7:0]) : 8'h00;
   end

   always_ff @(posedge clk_156m25) begin
      if (reset_156m25) state_q <= c_idle;
      else              state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         c_idle, c_done: begin
            if (start) state_d = c_send;
         end
         c_send: begin
            if (w_fire && w_last) begin
               if (w_finish)          state_d = c_done;
               else if (gap_q != '0)  state_d = c_gap;
            end
         end
         c_gap: begin
            if (stop)                          state_d = c_done;
            else if (gap_cnt_q <= GAP_W'(1))   state_d = c_send;
         end
         default: state_d = c_idle;
      endcase
   end

   always_comb begin
      cur_len_d   = cur_len_q;
      boff_d      = boff_q;
      pkt_idx_d   = pkt_idx_q;
      pkt_sent_d  = pkt_sent_q;
      gap_cnt_d   = gap_cnt_q;
      stop_seen_d = stop_seen_q;
      num_pkts_d  = num_pkts_q;
      len_incr_d  = len_incr_q;
      gap_d       = gap_q;
      data_d      = '0;
      val_d       = 1'b0;
      sop_d       = 1'b0;
      eop_d       = 1'b0;
      mod_d       = '0;
      busy_d      = (state_d == c_send) || (state_d == c_gap);
      done_d      = (state_d == c_done);
      case (state_q)
         c_idle, c_done: begin
            if (start) begin
               num_pkts_d  = num_pkts;
               len_incr_d  = len_incr;
               gap_d       = gap_cycles;
               cur_len_d   = clamp_len(len_cfg);
               pkt_idx_d   = '0;
               pkt_sent_d  = '0;
               boff_d      = '0;
               stop_seen_d = 1'b0;
            end
         end
         c_send: begin
            stop_seen_d = stop_seen_q | stop;
            if (w_fire) begin
               val_d  = 1'b1;
               data_d = w_word;
               sop_d  = (boff_q == '0);
               if (boff_q == '0) stop_seen_d = stop;
               if (w_last) begin
                  eop_d      = 1'b1;
                  mod_d      = cur_len_q[MOD_W-1:0];
                  pkt_sent_d = w_sent_inc;
                  pkt_idx_d  = pkt_idx_q + CNT_W'(1);
                  boff_d     = '0;
                  gap_cnt_d  = gap_q;
                  if (len_incr_q)
                     cur_len_d = (cur_len_q >= c_max_len) ? c_min_len : cur_len_q + LEN_W'(1);
               end else begin
                  boff_d = boff_q + LEN_W'(c_bytes);
               end
            end
         end
         c_gap: begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_156m25) begin
      if (reset_156m25) begin
         cur_len_q   <= '0;
         boff_q      <= '0;
         pkt_idx_q   <= '0;
         pkt_sent_q  <= '0;
         gap_cnt_q   <= '0;
         stop_seen_q <= 1'b0;
         num_pkts_q  <= '0;
         len_incr_q  <= 1'b0;
         gap_q       <= '0;
         data_q      <= '0;
         val_q       <= 1'b0;
         sop_q       <= 1'b0;
         eop_q       <= 1'b0;
         mod_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         cur_len_q   <= cur_len_d;
         boff_q      <= boff_d;
         pkt_idx_q   <= pkt_idx_d;
         pkt_sent_q  <= pkt_sent_d;
         gap_cnt_q   <= gap_cnt_d;
         stop_seen_q <= stop_seen_d;
         num_pkts_q  <= num_pkts_d;
         len_incr_q  <= len_incr_d;
         gap_q       <= gap_d;
         data_q      <= data_d;
         val_q       <= val_d;
         sop_q       <= sop_d;
         eop_q       <= eop_d;
         mod_q       <= mod_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign pkt_tx_data = data_q;
   assign pkt_tx_val  = val_q;
   assign pkt_tx_sop  = sop_q;
   assign pkt_tx_eop  = eop_q;
   assign pkt_tx_mod  = mod_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign pkt_sent    = pkt_sent_q;

endmodule
`default_nettype wire

// File: tb/tb_xge_pkt_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_xge_pkt_gen
// Function : Self-checking bench for xge_pkt_gen (64-bit data path).
// Revision : 1.0
// ============================================================================
module tb_xge_pkt_gen;

   logic        clk_156m25;
   logic        reset_156m25;
   logic        start;
   logic [31:0] num_pkts;
   logic        stop;
   logic [13:0] len_cfg;
   logic        len_incr;
   logic [7:0]  gap_cycles;
   logic        pkt_tx_full;
   logic [63:0] pkt_tx_data;
   logic        pkt_tx_val;
   logic        pkt_tx_sop;
   logic        pkt_tx_eop;
   logic [2:0]  pkt_tx_mod;
   logic        busy;
   logic        done;
   logic [31:0] pkt_sent;

   int checks = 0;
   int errors = 0;

   xge_pkt_gen dut (
      .clk_156m25   (clk_156m25),
      .reset_156m25 (reset_156m25),
      .start        (start),
      .num_pkts     (num_pkts),
      .stop         (stop),
      .len_cfg      (len_cfg),
      .len_incr     (len_incr),
      .gap_cycles   (gap_cycles),
      .pkt_tx_full  (pkt_tx_full),
      .pkt_tx_data  (pkt_tx_data),
      .pkt_tx_val   (pkt_tx_val),
      .pkt_tx_sop   (pkt_tx_sop),
      .pkt_tx_eop   (pkt_tx_eop),
      .pkt_tx_mod   (pkt_tx_mod),
      .busy         (busy),
      .done         (done),
      .pkt_sent     (pkt_sent)
   );

   initial clk_156m25 = 1'b0;
   always #5 clk_156m25 = ~clk_156m25;

   typedef struct {
      int          len;
      int          npkts;
      int          gap;
      bit          incr;
      int          full_at;
      int          full_len;
      int          stop_pkt;
      bit          stop_at_start;
      int          exp_pkts;
      logic [63:0] exp_last_w;
      int          exp_last_mod;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_156m25);
      #1;
   endtask

   task automatic pulse_start(input bit with_stop);
      start = 1'b1;
      stop  = with_stop;
      tick();
      start = 1'b0;
      stop  = 1'b0;
   endtask

   function automatic int clampl(input int l);
      if (l < 64)   return 64;
      if (l > 9600) return 9600;
      return l;
   endfunction

   function automatic logic [63:0] exp_word(input int p, input int k, input int l);
      logic [63:0] w;
      w = '0;
      for (int j = 0; j < 8; j++)
         if (k + j < l) w[63-8*j -: 8] = 8'((p + k + j) % 256);
      return w;
   endfunction

   task automatic run_vec(input int idx, input vec_t v);
      int          p, k, l, cyc, idle, stall, last_mod, emod;
      bit          fin, stopped, eflag;
      logic [63:0] last_w;
      string       t;
      t          = $sformatf("v%0d", idx);
      len_cfg    = 14'(v.len);
      num_pkts   = 32'(v.npkts);
      gap_cycles = 8'(v.gap);
      len_incr   = v.incr;
      pulse_start(v.stop_at_start);
      p = 0; k = 0; l = clampl(v.len); cyc = 0; idle = 0; stall = 0;
      fin = 0; stopped = 0; last_w = '0; last_mod = -1;
      while (!fin && cyc < 20000) begin
         tick();
         cyc++;
         if (pkt_tx_full) check({t, " val_after_full"}, 64'(pkt_tx_val), 64'd0);
         if (pkt_tx_val) begin
            check({t, " data"}, pkt_tx_data, exp_word(p, k, l));
            eflag = (k + 8 >= l);
            emod  = eflag ? (l % 8) : 0;
            check({t, " flags"}, {59'd0, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod},
                  {59'd0, (k == 0), eflag, 3'(emod)});
            if (k == 0 && p > 0 && v.full_len == 0)
               check({t, " gap"}, 64'(idle), 64'(v.gap));
            if (eflag) begin
               last_w   = pkt_tx_data;
               last_mod = int'(pkt_tx_mod);
               p++;
               k    = 0;
               idle = 0;
               if (v.incr) l = (l >= 9600) ? 64 : l + 1;
            end else begin
               k += 8;
            end
         end else begin
            check({t, " idle_flags"}, {62'd0, pkt_tx_sop, pkt_tx_eop}, 64'd0);
            idle++;
            if (p == 0 && k > 0) stall++;
         end
         if (done) fin = 1;
         pkt_tx_full = (cyc >= v.full_at) && (cyc < v.full_at + v.full_len);
         stop = 1'b0;
         if (!stopped && p == v.stop_pkt && k == 16) begin
            stop    = 1'b1;
            stopped = 1;
         end
      end
      pkt_tx_full = 1'b0;
      stop        = 1'b0;
      check({t, " finished"}, 64'(fin), 64'd1);
      check({t, " pkts_seen"}, 64'(p), 64'(v.exp_pkts));
      check({t, " pkt_sent"}, 64'(pkt_sent), 64'(v.exp_pkts));
      check({t, " last_word"}, last_w, v.exp_last_w);
      check({t, " last_mod"}, 64'(last_mod), 64'(v.exp_last_mod));
      check({t, " stalls"}, 64'(stall), 64'(v.full_len));
      check({t, " busy_done"}, {62'd0, busy, done}, 64'd1);
   endtask

   initial begin
      int n;
      //           len  npk gap incr fat flen stp sas exp  last word              mod
      vecs[0] = '{  64,  1,  0, 0,   -1,  0,  -1, 0,  1, 64'h38393a3b3c3d3e3f, 0};
      vecs[1] = '{  65,  2,  3, 0,   -1,  0,  -1, 0,  2, 64'h4100000000000000, 1};
      vecs[2] = '{  64,  2,  2, 0,    3,  5,  -1, 0,  2, 64'h393a3b3c3d3e3f40, 0};
      vecs[3] = '{9599,  3,  1, 1,   -1,  0,  -1, 0,  3, 64'h3a3b3c3d3e3f4041, 0};
      vecs[4] = '{  10,  1,  0, 0,   -1,  0,  -1, 0,  1, 64'h38393a3b3c3d3e3f, 0};
      vecs[5] = '{  64,  0,  1, 0,   -1,  0,   4, 0,  5, 64'h3c3d3e3f40414243, 0};
      vecs[6] = '{  70,  1,  0, 0,   -1,  0,  -1, 0,  1, 64'h4041424344450000, 6};
      vecs[7] = '{  64,  3,  0, 0,   -1,  0,  -1, 0,  3, 64'h3a3b3c3d3e3f4041, 0};
      vecs[8] = '{  64,  2,  0, 0,   -1,  0,  -1, 1,  2, 64'h393a3b3c3d3e3f40, 0};

      reset_156m25 = 1'b1;
      start = 0; stop = 0; num_pkts = 0; len_cfg = 0; len_incr = 0;
      gap_cycles = 0; pkt_tx_full = 0;
      repeat (3) tick();
      check("rst data", pkt_tx_data, 64'd0);
      check("rst ctrl", {57'd0, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, busy, done}, 64'd0);
      check("rst pkt_sent", 64'(pkt_sent), 64'd0);
      reset_156m25 = 1'b0;
      tick();

      // Stop alone in IDLE must not start anything.
      stop = 1'b1;
      tick();
      stop = 1'b0;
      tick();
      check("idle_stop busy_done", {62'd0, busy, done}, 64'd0);

      for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

      // Stop during GAP ends the run at once; start while busy is ignored.
      len_cfg = 64; num_pkts = 0; gap_cycles = 10; len_incr = 0;
      pulse_start(0);
      n = 0;
      do begin
         tick();
         n++;
      end while (!pkt_tx_eop && n < 100);
      check("gs eop_seen", 64'(pkt_tx_eop), 64'd1);
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b1;
      tick();
      stop  = 1'b0;
      check("gs busy_done", {62'd0, busy, done}, 64'd1);
      check("gs pkt_sent", 64'(pkt_sent), 64'd1);
      check("gs val", 64'(pkt_tx_val), 64'd0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      repeat (5) tick();
      check("done_hold busy_done", {62'd0, busy, done}, 64'd1);
      check("done_hold pkt_sent", 64'(pkt_sent), 64'd1);

      // Reset mid-packet, then a clean restart.
      len_cfg = 64; num_pkts = 3; gap_cycles = 0;
      pulse_start(0);
      repeat (12) tick();
      check("mid val", 64'(pkt_tx_val), 64'd1);
      reset_156m25 = 1'b1;
      tick();
      check("mid_rst data", pkt_tx_data, 64'd0);
      check("mid_rst ctrl", {57'd0, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod, busy, done}, 64'd0);
      check("mid_rst pkt_sent", 64'(pkt_sent), 64'd0);
      reset_156m25 = 1'b0;
      num_pkts = 1;
      tick();
      pulse_start(0);
      tick();
      check("restart sop_val", {62'd0, pkt_tx_sop, pkt_tx_val}, 64'd3);
      check("restart word0", pkt_tx_data, 64'h0001020304050607);
      n = 0;
      while (!done && n < 100) begin
         tick();
         n++;
      end
      check("restart done", 64'(done), 64'd1);
      check("restart pkt_sent", 64'(pkt_sent), 64'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
